// File: rtl/mem_arbiter.sv
// Memory port arbiter: shares one off-chip line port between the I-cache
// (line reads only) and the write-back D-cache (line reads and write-backs).
// One transaction is in flight at a time. The memory strobes are registered,
// and the completion is returned only to the cache that holds the grant.
module mem_arbiter #(
    parameter int ADDR_W = 28,
    parameter int LINE_W = 128,
    parameter int D_PRIO = 0
) (
    input  logic              clk,
    input  logic              proc_reset_n,
    input  logic              i_mem_read,
    input  logic [ADDR_W-1:0] i_mem_addr,
    output logic [LINE_W-1:0] i_mem_rdata,
    output logic              i_mem_ready,
    input  logic              d_mem_read,
    input  logic              d_mem_write,
    input  logic [ADDR_W-1:0] d_mem_addr,
    input  logic [LINE_W-1:0] d_mem_wdata,
    output logic [LINE_W-1:0] d_mem_rdata,
    output logic              d_mem_ready,
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [LINE_W-1:0] mem_wdata,
    input  logic [LINE_W-1:0] mem_rdata,
    input  logic              mem_ready,
    output logic              busy,
    output logic              grant_d
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SERVE_I = 2'd1,
        SERVE_D = 2'd2
    } state_t;

    state_t              state;
    state_t              state_next;
    logic                last_d;
    logic                last_d_next;
    logic                mem_read_next;
    logic                mem_write_next;
    logic [ADDR_W-1:0]   mem_addr_next;
    logic [LINE_W-1:0]   mem_wdata_next;
    logic                d_req;
    logic                d_wins;

    // The D-cache wants the port for either a line read or a write-back.
    // On a tie it wins under fixed priority, or when the I-cache had the
    // previous grant. last_d resets to 0, so D wins the first tie.
    assign d_req  = d_mem_read | d_mem_write;
    assign d_wins = d_req & (~i_mem_read | (D_PRIO != 0) | ~last_d);

    // State register and registered memory-side strobes, address and data
    always_ff @(posedge clk) begin
        if (!proc_reset_n) begin
            state     <= IDLE;
            last_d    <= 1'b0;
            mem_read  <= 1'b0;
            mem_write <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else begin
            state     <= state_next;
            last_d    <= last_d_next;
            mem_read  <= mem_read_next;
            mem_write <= mem_write_next;
            mem_addr  <= mem_addr_next;
            mem_wdata <= mem_wdata_next;
        end
    end

    // Next-state logic: grant from IDLE and latch the winner's request.
    // Hold everything while serving. Drop the strobes on memory completion.
    always_comb begin
        state_next     = state;
        last_d_next    = last_d;
        mem_read_next  = mem_read;
        mem_write_next = mem_write;
        mem_addr_next  = mem_addr;
        mem_wdata_next = mem_wdata;
        case (state)
            IDLE: begin
                if (d_wins) begin
                    state_next     = SERVE_D;
                    last_d_next    = 1'b1;
                    mem_addr_next  = d_mem_addr;
                    mem_write_next = d_mem_write;
                    mem_read_next  = d_mem_read & ~d_mem_write;
                    mem_wdata_next = d_mem_wdata;
                end else if (i_mem_read) begin
                    state_next     = SERVE_I;
                    last_d_next    = 1'b0;
                    mem_addr_next  = i_mem_addr;
                    mem_read_next  = 1'b1;
                    mem_write_next = 1'b0;
                end else begin
                    mem_read_next  = 1'b0;
                    mem_write_next = 1'b0;
                end
            end
            SERVE_I, SERVE_D: begin
                if (mem_ready) begin
                    state_next     = IDLE;
                    mem_read_next  = 1'b0;
                    mem_write_next = 1'b0;
                end
            end
            default: begin
                state_next     = IDLE;
                mem_read_next  = 1'b0;
                mem_write_next = 1'b0;
            end
        endcase
    end

    // Status flags. Both read-data buses carry the memory data as-is, and
    // only the granted ready qualifies it. The ready is also gated by reset,
    // so an abandoned transaction never completes.
    assign busy        = (state != IDLE);
    assign grant_d     = (state == SERVE_D);
    assign i_mem_ready = (state == SERVE_I) & mem_ready & proc_reset_n;
    assign d_mem_ready = (state == SERVE_D) & mem_ready & proc_reset_n;
    assign i_mem_rdata = mem_rdata;
    assign d_mem_rdata = mem_rdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: unit 0 is round-robin and unit 1 is D-priority.
// A transaction-level reference model, built from the arbitration rules,
// predicts every output of both units on every cycle. Directed steps come
// first, followed by a randomized client and memory traffic phase.
module tb_mem_arbiter;

    logic clk = 1'b0;

    logic         rst_n     [2];
    logic         i_read    [2];
    logic [27:0]  i_addr    [2];
    logic         d_read    [2];
    logic         d_write   [2];
    logic [27:0]  d_addr    [2];
    logic [127:0] d_wdata   [2];
    logic [127:0] m_rdata   [2];
    logic         m_ready   [2];

    logic [127:0] i_rdata_o [2];
    logic         i_ready_o [2];
    logic [127:0] d_rdata_o [2];
    logic         d_ready_o [2];
    logic         m_read_o  [2];
    logic         m_write_o [2];
    logic [27:0]  m_addr_o  [2];
    logic [127:0] m_wdata_o [2];
    logic         busy_o    [2];
    logic         grant_d_o [2];

    // reference model: owner 0 = none, 1 = I-cache, 2 = D-cache
    int           own       [2];
    bit           last_d    [2];
    logic         e_read    [2];
    logic         e_write   [2];
    logic [27:0]  e_addr    [2];
    logic [127:0] e_wdata   [2];

    bit           i_done    [2];
    bit           d_done    [2];

    int total = 0;
    int bad   = 0;

    // free-running clock
    always #5 clk = ~clk;

    mem_arbiter #(.ADDR_W(28), .LINE_W(128), .D_PRIO(0)) u_rr (
        .clk(clk), .proc_reset_n(rst_n[0]),
        .i_mem_read(i_read[0]), .i_mem_addr(i_addr[0]),
        .i_mem_rdata(i_rdata_o[0]), .i_mem_ready(i_ready_o[0]),
        .d_mem_read(d_read[0]), .d_mem_write(d_write[0]),
        .d_mem_addr(d_addr[0]), .d_mem_wdata(d_wdata[0]),
        .d_mem_rdata(d_rdata_o[0]), .d_mem_ready(d_ready_o[0]),
        .mem_read(m_read_o[0]), .mem_write(m_write_o[0]),
        .mem_addr(m_addr_o[0]), .mem_wdata(m_wdata_o[0]),
        .mem_rdata(m_rdata[0]), .mem_ready(m_ready[0]),
        .busy(busy_o[0]), .grant_d(grant_d_o[0])
    );

    mem_arbiter #(.ADDR_W(28), .LINE_W(128), .D_PRIO(1)) u_fp (
        .clk(clk), .proc_reset_n(rst_n[1]),
        .i_mem_read(i_read[1]), .i_mem_addr(i_addr[1]),
        .i_mem_rdata(i_rdata_o[1]), .i_mem_ready(i_ready_o[1]),
        .d_mem_read(d_read[1]), .d_mem_write(d_write[1]),
        .d_mem_addr(d_addr[1]), .d_mem_wdata(d_wdata[1]),
        .d_mem_rdata(d_rdata_o[1]), .d_mem_ready(d_ready_o[1]),
        .mem_read(m_read_o[1]), .mem_write(m_write_o[1]),
        .mem_addr(m_addr_o[1]), .mem_wdata(m_wdata_o[1]),
        .mem_rdata(m_rdata[1]), .mem_ready(m_ready[1]),
        .busy(busy_o[1]), .grant_d(grant_d_o[1])
    );

    task automatic chk(input int u, input string tag, input logic [127:0] obs, input logic [127:0] want);
        total++;
        assert (obs === want) else begin
            bad++;
            $error("[TB] FAIL u%0d %s observed=%0h expected=%0h", u, tag, obs, want);
        end
    endtask

    // compare every DUT output of one unit against the model's prediction
    task automatic check_output(input int u);
        logic ready_now;
        ready_now = (rst_n[u] === 1'b1) && (m_ready[u] === 1'b1);
        chk(u, "i_mem_ready", i_ready_o[u], ready_now && own[u] == 1);
        chk(u, "d_mem_ready", d_ready_o[u], ready_now && own[u] == 2);
        chk(u, "i_mem_rdata", i_rdata_o[u], m_rdata[u]);
        chk(u, "d_mem_rdata", d_rdata_o[u], m_rdata[u]);
        chk(u, "busy", busy_o[u], own[u] != 0);
        chk(u, "grant_d", grant_d_o[u], own[u] == 2);
        chk(u, "mem_read", m_read_o[u], e_read[u]);
        chk(u, "mem_write", m_write_o[u], e_write[u]);
        chk(u, "mem_addr", m_addr_o[u], e_addr[u]);
        chk(u, "mem_wdata", m_wdata_o[u], e_wdata[u]);
    endtask

    // apply the arbitration rules to the inputs sampled at a clock edge
    task automatic model_edge(input int u);
        bit d_any;
        if (rst_n[u] !== 1'b1) begin
            own[u] = 0; last_d[u] = 1'b0;
            e_read[u] = 1'b0; e_write[u] = 1'b0; e_addr[u] = '0; e_wdata[u] = '0;
        end else if (own[u] != 0) begin
            if (m_ready[u] === 1'b1) begin
                own[u] = 0; e_read[u] = 1'b0; e_write[u] = 1'b0;
            end
        end else begin
            d_any = d_read[u] | d_write[u];
            if (d_any && (!i_read[u] || u == 1 || !last_d[u])) begin
                own[u] = 2; last_d[u] = 1'b1;
                e_addr[u] = d_addr[u]; e_wdata[u] = d_wdata[u];
                e_write[u] = d_write[u]; e_read[u] = d_read[u] & ~d_write[u];
            end else if (i_read[u]) begin
                own[u] = 1; last_d[u] = 1'b0;
                e_addr[u] = i_addr[u]; e_read[u] = 1'b1; e_write[u] = 1'b0;
            end else begin
                e_read[u] = 1'b0; e_write[u] = 1'b0;
            end
        end
    endtask

    // one clock cycle: check both units, take the edge, advance both models
    task automatic cycle();
        #1;
        for (int u = 0; u < 2; u++) check_output(u);
        @(posedge clk);
        for (int u = 0; u < 2; u++) model_edge(u);
        #1;
    endtask

    task automatic clear_inputs(input int u);
        i_read[u] = 1'b0; i_addr[u] = '0;
        d_read[u] = 1'b0; d_write[u] = 1'b0; d_addr[u] = '0; d_wdata[u] = '0;
        m_ready[u] = 1'b0; m_rdata[u] = '0;
    endtask

    // both clients request until served n_d / n_i times; memory answers one
    // cycle after the grant; the grant order is recorded and checked
    task automatic apply_stimulus_contend(input int u, input int n_d, input int n_i,
                                          input bit want_order[4], input string name);
        int   sd  = 0;
        int   si  = 0;
        int   cyc = 0;
        logic prev_busy;
        bit   got[$];
        prev_busy = busy_o[u];
        while ((sd < n_d || si < n_i) && cyc < 200) begin
            i_read[u]  = (si < n_i);
            i_addr[u]  = 28'h100 + 28'(si);
            d_read[u]  = (sd < n_d);
            d_write[u] = 1'b0;
            d_addr[u]  = 28'h200 + 28'(sd);
            m_ready[u] = busy_o[u];
            m_rdata[u] = {$urandom, $urandom, $urandom, $urandom};
            #1;
            if (i_ready_o[u] === 1'b1) si++;
            if (d_ready_o[u] === 1'b1) sd++;
            cycle();
            if (busy_o[u] === 1'b1 && prev_busy !== 1'b1) got.push_back(grant_d_o[u]);
            prev_busy = busy_o[u];
            cyc++;
        end
        chk(u, {name, " served_d"}, 128'(sd), 128'(n_d));
        chk(u, {name, " served_i"}, 128'(si), 128'(n_i));
        chk(u, {name, " grants"}, 128'(got.size()), 128'd4);
        for (int k = 0; k < 4; k++)
            if (k < got.size()) chk(u, $sformatf("%s order[%0d]", name, k), 128'(got[k]), 128'(want_order[k]));
        clear_inputs(u);
        cycle();
    endtask

    // directed steps followed by random traffic
    initial begin
        for (int u = 0; u < 2; u++) begin
            rst_n[u] = 1'b0;
            clear_inputs(u);
            i_done[u] = 1'b0; d_done[u] = 1'b0;
        end
        @(posedge clk);
        for (int u = 0; u < 2; u++) model_edge(u);
        #1;
        cycle();
        rst_n[0] = 1'b1; rst_n[1] = 1'b1;
        #1;
        for (int u = 0; u < 2; u++) begin
            chk(u, "reset mem_read", m_read_o[u], 1'b0);
            chk(u, "reset mem_addr", m_addr_o[u], 28'h0);
            chk(u, "reset mem_wdata", m_wdata_o[u], 128'h0);
            chk(u, "reset busy", busy_o[u], 1'b0);
        end

        // I-cache line read, memory answers on the fourth serve cycle
        i_read[0] = 1'b1; i_addr[0] = 28'h0000010;
        cycle();
        chk(0, "t1 mem_read", m_read_o[0], 1'b1);
        chk(0, "t1 mem_addr", m_addr_o[0], 28'h0000010);
        chk(0, "t1 grant_d", grant_d_o[0], 1'b0);
        cycle(); cycle(); cycle();
        chk(0, "t1 early ready", i_ready_o[0], 1'b0);
        m_ready[0] = 1'b1; m_rdata[0] = {16{8'hA5}};
        #1;
        chk(0, "t1 i_ready", i_ready_o[0], 1'b1);
        chk(0, "t1 i_rdata", i_rdata_o[0], {16{8'hA5}});
        chk(0, "t1 d_ready", d_ready_o[0], 1'b0);
        cycle();
        i_read[0] = 1'b0; m_ready[0] = 1'b0;
        #1;
        chk(0, "t1 mem_read after", m_read_o[0], 1'b0);
        chk(0, "t1 i_ready after", i_ready_o[0], 1'b0);
        cycle();

        // D-cache write-back
        d_write[0] = 1'b1; d_addr[0] = 28'h0000123; d_wdata[0] = {4{32'hDEADBEEF}};
        cycle();
        chk(0, "t2 mem_write", m_write_o[0], 1'b1);
        chk(0, "t2 mem_read", m_read_o[0], 1'b0);
        chk(0, "t2 mem_wdata", m_wdata_o[0], {4{32'hDEADBEEF}});
        chk(0, "t2 mem_addr", m_addr_o[0], 28'h0000123);
        m_ready[0] = 1'b1;
        #1;
        chk(0, "t2 d_ready", d_ready_o[0], 1'b1);
        chk(0, "t2 i_ready", i_ready_o[0], 1'b0);
        cycle();
        d_write[0] = 1'b0; m_ready[0] = 1'b0;
        #1;
        chk(0, "t2 busy after", busy_o[0], 1'b0);
        cycle();

        // reset while serving I abandons the transaction
        i_read[0] = 1'b1; i_addr[0] = 28'h0000040;
        cycle();
        chk(0, "t3 busy", busy_o[0], 1'b1);
        rst_n[0] = 1'b0;
        cycle();
        chk(0, "t3 mem_read", m_read_o[0], 1'b0);
        chk(0, "t3 busy", busy_o[0], 1'b0);
        rst_n[0] = 1'b1; i_read[0] = 1'b0; m_ready[0] = 1'b1;
        #1;
        chk(0, "t3 idle i_ready", i_ready_o[0], 1'b0);
        chk(0, "t3 idle d_ready", d_ready_o[0], 1'b0);
        cycle();
        m_ready[0] = 1'b0;
        cycle();

        // round-robin alternation and fixed D priority
        apply_stimulus_contend(0, 2, 2, '{1'b1, 1'b0, 1'b1, 1'b0}, "rr");
        apply_stimulus_contend(1, 3, 1, '{1'b1, 1'b1, 1'b1, 1'b0}, "prio");

        // read and write together: the write is issued alone
        d_read[0] = 1'b1; d_write[0] = 1'b1; d_addr[0] = 28'h0000055; d_wdata[0] = {4{32'h01234567}};
        cycle();
        chk(0, "t6 mem_write", m_write_o[0], 1'b1);
        chk(0, "t6 mem_read", m_read_o[0], 1'b0);
        m_ready[0] = 1'b1;
        cycle();
        clear_inputs(0);
        cycle();

        // randomized clients, memory latency, stray readies and resets
        for (int c = 0; c < 800; c++) begin
            for (int u = 0; u < 2; u++) begin
                rst_n[u] = ($urandom_range(0, 59) != 0);
                if (!i_read[u] || i_done[u]) begin
                    i_read[u] = $urandom_range(0, 1) == 1;
                    i_addr[u] = 28'($urandom);
                end
                if (!(d_read[u] | d_write[u]) || d_done[u]) begin
                    d_read[u]  = $urandom_range(0, 2) == 0;
                    d_write[u] = $urandom_range(0, 2) == 0;
                    d_addr[u]  = 28'($urandom);
                    d_wdata[u] = {$urandom, $urandom, $urandom, $urandom};
                end
                m_ready[u] = $urandom_range(0, 3) == 0;
                m_rdata[u] = {$urandom, $urandom, $urandom, $urandom};
            end
            #1;
            for (int u = 0; u < 2; u++) begin
                i_done[u] = (i_ready_o[u] === 1'b1);
                d_done[u] = (d_ready_o[u] === 1'b1);
            end
            cycle();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares the single off-chip memory port between the read-only I-cache and the write-back D-cache of the 5-stage pipeline.
- Sits between both cache controllers and main memory.
- Accepts one line transaction at a time (128-bit line read or write-back), forwards it to memory, and returns `mem_ready`/`rdata` only to the granted cache.
- Ties are resolved round-robin or by fixed D-cache priority.

Parameters:
ADDR_W, 28, line address width (word address bits [29:2])
LINE_W, 128, line width in bits
D_PRIO, 0, 0 = round-robin on simultaneous requests; 1 = D-cache always wins

Ports:
clk  input  1  clock, all state on rising edge
proc_reset_n  input  1  synchronous, active-low reset
i_mem_read  input  1  I-cache line-read request, held until i_mem_ready
i_mem_addr  input  ADDR_W  I-cache line address
i_mem_rdata  output  LINE_W  line data to I-cache
i_mem_ready  output  1  I-cache transaction complete (1 cycle)
d_mem_read  input  1  D-cache line-read request
d_mem_write  input  1  D-cache line write-back request
d_mem_addr  input  ADDR_W  D-cache line address
d_mem_wdata  input  LINE_W  D-cache write-back data
d_mem_rdata  output  LINE_W  line data to D-cache
d_mem_ready  output  1  D-cache transaction complete (1 cycle)
mem_read  output  1  memory read strobe, registered
mem_write  output  1  memory write strobe, registered
mem_addr  output  ADDR_W  memory line address, registered
mem_wdata  output  LINE_W  memory write data, registered
mem_rdata  input  LINE_W  memory read data, valid when mem_ready
mem_ready  input  1  memory completion, 1 cycle
busy  output  1  high in any SERVE state
grant_d  output  1  high while serving D-cache

Behaviour:
- Reset (proc_reset_n low at clk edge):
  - State = IDLE; last_grant = I, so D wins the first tie.
  - mem_read = 0, mem_write = 0, mem_addr = 0, mem_wdata = 0.
  - busy = 0, grant_d = 0; i_mem_ready = 0, d_mem_ready = 0.
  - Reset mid-transaction abandons the transaction. No ready is returned; memory sees the strobe drop the next cycle.
- FSM states: IDLE, SERVE_I, SERVE_D.
- IDLE:
  - Sample requests. d_req = d_mem_read | d_mem_write.
  - Only one requester pending: grant it.
  - Both pending, D_PRIO = 1: grant D.
  - Both pending, D_PRIO = 0: grant the one not equal to last_grant.
  - On grant, register the memory outputs at the same edge:
    - mem_addr = granted addr.
    - For D: mem_write = d_mem_write, mem_read = d_mem_read & ~d_mem_write (write wins if both are high), mem_wdata = d_mem_wdata.
    - For I: mem_read = 1, mem_write = 0, mem_wdata unchanged.
  - Update last_grant and go to SERVE_x.
  - No request: stay in IDLE, strobes 0.
- SERVE_x:
  - mem_read/mem_write/mem_addr/mem_wdata held constant. Later changes on client inputs are ignored.
  - When mem_ready = 1: the granted client's x_mem_ready = 1 combinationally in the same cycle, and x_mem_rdata = mem_rdata.
  - Next edge: strobes cleared, state returns to IDLE.
- Latency: request seen at edge N, strobe visible in cycle N+1. Minimum transaction is 2 cycles plus memory latency.
- There is always ≥1 IDLE cycle between transactions, so a client that drops its request on ready is never re-granted spuriously.
- Ready/data isolation:
  - The non-granted ready is always 0.
  - i_mem_rdata and d_mem_rdata both carry mem_rdata unconditionally; only ready qualifies the data.
  - mem_ready in IDLE is ignored and returns no client ready.
- Requests are level-held. A request dropped before grant is never served. A request dropped during its own service does not abort it; ready is still pulsed.
- D write-back followed by D allocate are two independent transactions. In round-robin mode an I transaction may be interleaved between them.
- No starvation: with D_PRIO = 0 and both requesting continuously, grants alternate D, I, D, I.

Test Plan:
- Reset, then i_mem_read = 1, i_mem_addr = 28'h0000010 -> next cycle mem_read = 1, mem_addr = 28'h0000010, grant_d = 0. Memory returns ready after 3 cycles with rdata = 128'hA5…A5 -> i_mem_ready pulses 1 cycle with that data, d_mem_ready stays 0; mem_read = 0 the following cycle.
- d_mem_write = 1, d_mem_addr = 28'h0000123, d_mem_wdata = 128'hDEADBEEF… -> mem_write = 1, mem_read = 0, mem_wdata matches. On ready, d_mem_ready pulses and busy drops next cycle.
- D_PRIO = 0, both requesting continuously, ready after 1 cycle -> grant order D, I, D, I over 4 transactions, with an IDLE cycle between each.
- D_PRIO = 1, both requesting for 3 D transactions -> all 3 served to D before I; I served once D is idle.
- Grant I, then assert proc_reset_n = 0 in SERVE_I before ready -> mem_read = 0 next cycle, state IDLE, no i_mem_ready. A later mem_ready pulse in IDLE is ignored.
- d_mem_read = d_mem_write = 1 together -> write issued only (mem_write = 1, mem_read = 0).
